// File: rtl/edge_result_reader_pkg.sv
// Shared definitions for the edge accumulator readout path:
// FSM state encoding and the geometry of the 2048-bit result array.
package edge_result_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PUSH    = 3'd3,
        ST_FIN     = 3'd4
    } rd_state_t;

    localparam int RD_WORDS          = 64;
    localparam int RD_WORD_W         = 32;
    localparam int RD_BANKS          = 4;
    localparam int RD_WORDS_PER_BANK = 16;

    localparam logic [5:0] RD_LAST_IDX = 6'(RD_WORDS - 1);

endpackage

// File: rtl/edge_result_reader_popcount32.sv
// Combinational 32-bit population count built as a balanced adder tree.
// Reusable by any stage that needs the edge density of one result word.
module popcount32 (
    input  logic [31:0] din,
    output logic [5:0]  count
);

    logic [1:0] lvl1 [16];
    logic [2:0] lvl2 [8];
    logic [3:0] lvl3 [4];
    logic [4:0] lvl4 [2];

    // Pairwise reduction: each level adds neighbours and widens by one bit.
    // NOTE: every output of a combinational block is assigned on every pass, so no latch can form.
    always_comb begin
        for (int i = 0; i < 16; i++) lvl1[i] = {1'b0, din[2*i]}   + {1'b0, din[2*i+1]};
        for (int i = 0; i < 8;  i++) lvl2[i] = {1'b0, lvl1[2*i]}  + {1'b0, lvl1[2*i+1]};
        for (int i = 0; i < 4;  i++) lvl3[i] = {1'b0, lvl2[2*i]}  + {1'b0, lvl2[2*i+1]};
        for (int i = 0; i < 2;  i++) lvl4[i] = {1'b0, lvl3[2*i]}  + {1'b0, lvl3[2*i+1]};
        count = {1'b0, lvl4[0]} + {1'b0, lvl4[1]};
    end

endmodule

// File: rtl/edge_result_reader.sv
// Readout stage for the 2048-bit edge accumulator. Walks the bank/word read
// mux, samples each 32-bit word after a settle delay, streams it out over
// valid/ready tagged with its index, and accumulates the total edge count.
module edge_result_reader
    import edge_result_reader_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter bit SKIP_ZERO  = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  sel1,
    output logic [7:0]  sel2,
    input  logic [31:0] result_imp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_index,
    output logic        out_last,
    output logic [11:0] total_ones
);

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);

    rd_state_t   state;
    rd_state_t   state_nxt;
    logic [5:0]  idx;
    logic [2:0]  settle_cnt;
    logic [5:0]  word_ones;
    logic        settle_end;
    logic        is_last;
    logic        skip_word;
    logic        handshake;

    popcount32 u_popcount (
        .din   (result_imp),
        .count (word_ones)
    );

    assign settle_end = (settle_cnt == SETTLE_LAST);
    assign is_last    = (idx == RD_LAST_IDX);
    assign skip_word  = SKIP_ZERO && (result_imp == 32'h0) && !is_last;
    assign handshake  = out_valid & out_ready;

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; done is a pure decode of FIN.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_SETTLE;
            ST_SETTLE:  if (settle_end) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = skip_word ? ST_SETTLE : ST_PUSH;
            ST_PUSH:    if (handshake) state_nxt = is_last ? ST_FIN : ST_SETTLE;
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: word index, read select, settle timer, output holding regs, edge total.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            busy       <= 1'b0;
            idx        <= 6'd0;
            settle_cnt <= 3'd0;
            sel1       <= 2'd0;
            sel2       <= 8'd0;
            out_valid  <= 1'b0;
            out_data   <= 32'h0;
            out_index  <= 6'd0;
            out_last   <= 1'b0;
            total_ones <= 12'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx        <= 6'd0;
                        total_ones <= 12'd0;
                        busy       <= 1'b1;
                        settle_cnt <= 3'd0;
                    end
                end
                ST_SETTLE: begin
                    sel1       <= idx[5:4];
                    sel2       <= {4'b0000, idx[3:0]};
                    settle_cnt <= settle_end ? 3'd0 : settle_cnt + 3'd1;
                end
                ST_CAPTURE: begin
                    out_data   <= result_imp;
                    out_index  <= idx;
                    out_last   <= is_last;
                    total_ones <= total_ones + {6'd0, word_ones};
                    if (skip_word) idx <= idx + 6'd1;
                    else           out_valid <= 1'b1;
                end
                ST_PUSH: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (!is_last) idx <= idx + 6'd1;
                    end
                end
                ST_FIN: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_result_reader.sv
// Directed bench for edge_result_reader: one instance with SKIP_ZERO=0 and
// one with SKIP_ZERO=1, each fed by a behavioural accumulator model.
module tb_edge_result_reader;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        start_drv;
    logic        ready_drv;
    logic        use_b;
    int          pattern;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic        busy_a, done_a, valid_a, last_a;
    logic [1:0]  sel1_a;
    logic [7:0]  sel2_a;
    logic [31:0] result_a, data_a;
    logic [5:0]  index_a;
    logic [11:0] total_a;

    logic        busy_b, done_b, valid_b, last_b;
    logic [1:0]  sel1_b;
    logic [7:0]  sel2_b;
    logic [31:0] result_b, data_b;
    logic [5:0]  index_b;
    logic [11:0] total_b;

    always #5 CLK = ~CLK;

    // Accumulator contents for each stimulus pattern, word k = {sel1, sel2[3:0]}.
    function automatic logic [31:0] acc_word(input int pat, input int k);
        case (pat)
            0:       return 32'h0000_0001 << (k % 32);
            1:       return 32'hFFFF_FFFF;
            2:       return (k == 5 || k == 40) ? 32'hA5A5_0000 : 32'h0;
            default: return 32'(k + 1) * 32'h9E37_79B9;
        endcase
    endfunction

    function automatic logic [11:0] model_ones(input int pat);
        int s = 0;
        for (int k = 0; k < 64; k++) s += $countones(acc_word(pat, k));
        return 12'(s);
    endfunction

    assign result_a = acc_word(pattern, int'({sel1_a, sel2_a[3:0]}));
    assign result_b = acc_word(pattern, int'({sel1_b, sel2_b[3:0]}));

    edge_result_reader #(.SETTLE_CYC(1), .SKIP_ZERO(1'b0)) dut_a (
        .CLK(CLK), .RST_n(RST_n), .start(start_drv & ~use_b), .busy(busy_a), .done(done_a),
        .sel1(sel1_a), .sel2(sel2_a), .result_imp(result_a), .out_valid(valid_a),
        .out_ready(ready_drv & ~use_b), .out_data(data_a), .out_index(index_a),
        .out_last(last_a), .total_ones(total_a)
    );

    edge_result_reader #(.SETTLE_CYC(1), .SKIP_ZERO(1'b1)) dut_b (
        .CLK(CLK), .RST_n(RST_n), .start(start_drv & use_b), .busy(busy_b), .done(done_b),
        .sel1(sel1_b), .sel2(sel2_b), .result_imp(result_b), .out_valid(valid_b),
        .out_ready(ready_drv & use_b), .out_data(data_b), .out_index(index_b),
        .out_last(last_b), .total_ones(total_b)
    );

    // Unified view of whichever instance is under test.
    logic        v_busy, v_done, v_valid, v_last;
    logic [1:0]  v_sel1;
    logic [7:0]  v_sel2;
    logic [31:0] v_data;
    logic [5:0]  v_index;
    logic [11:0] v_total;
    assign v_busy  = use_b ? busy_b  : busy_a;
    assign v_done  = use_b ? done_b  : done_a;
    assign v_valid = use_b ? valid_b : valid_a;
    assign v_last  = use_b ? last_b  : last_a;
    assign v_sel1  = use_b ? sel1_b  : sel1_a;
    assign v_sel2  = use_b ? sel2_b  : sel2_a;
    assign v_data  = use_b ? data_b  : data_a;
    assign v_index = use_b ? index_b : index_a;
    assign v_total = use_b ? total_b : total_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_busy",  32'(v_busy),  32'd0);
        check("rst_done",  32'(v_done),  32'd0);
        check("rst_sel1",  32'(v_sel1),  32'd0);
        check("rst_sel2",  32'(v_sel2),  32'd0);
        check("rst_valid", 32'(v_valid), 32'd0);
        check("rst_data",  v_data,       32'd0);
        check("rst_index", 32'(v_index), 32'd0);
        check("rst_last",  32'(v_last),  32'd0);
        check("rst_total", 32'(v_total), 32'd0);
    endtask

    // One full scan: start, consume words with the given ready duty, check order,
    // data, last flag, stability under back-pressure, done and the edge total.
    task automatic run_scan(input bit dut_b_sel, input int pat, input int ready_pct,
                            input bit timing, input bit poke_start,
                            input int exp_words, input logic [11:0] exp_ones);
        int          q[$];
        int          nwords;
        int          first_v;
        int          second_v;
        int          exp_k;
        int          extra;
        bit          stall;
        bit          seen_done;
        logic [31:0] p_data;
        logic [5:0]  p_idx;
        logic        p_last;
        logic [1:0]  p_s1;
        logic [7:0]  p_s2;

        use_b   = dut_b_sel;
        pattern = pat;
        for (int k = 0; k < 64; k++)
            if (!(dut_b_sel && acc_word(pat, k) == 32'h0 && k != 63)) q.push_back(k);

        @(negedge CLK);
        start_drv = 1'b1;
        ready_drv = 1'b0;
        @(negedge CLK);
        start_drv = 1'b0;
        check("busy_on_start", 32'(v_busy), 32'd1);
        check("ones_cleared",  32'(v_total), 32'd0);

        nwords = 0; first_v = -1; second_v = -1; stall = 1'b0; seen_done = 1'b0;
        p_data = '0; p_idx = '0; p_last = 1'b0; p_s1 = '0; p_s2 = '0;
        for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
            if (poke_start) start_drv = (cyc == 3 || cyc == 20);
            if (stall) begin
                check("hold_valid", 32'(v_valid), 32'd1);
                check("hold_data",  v_data,        p_data);
                check("hold_index", 32'(v_index), 32'(p_idx));
                check("hold_last",  32'(v_last),  32'(p_last));
                check("hold_sel",   32'({v_sel1, v_sel2}), 32'({p_s1, p_s2}));
            end
            ready_drv = ($urandom_range(99) < ready_pct);
            if (v_valid) begin
                if (!stall) begin
                    if (first_v < 0)       first_v  = cyc;
                    else if (second_v < 0) second_v = cyc;
                end
                check("sel_vs_index", 32'({v_sel1, v_sel2}),
                      32'({v_index[5:4], 4'b0000, v_index[3:0]}));
                if (ready_drv) begin
                    if (q.size() == 0) begin
                        check("extra_word", 32'(v_index), 32'hFFFF);
                    end else begin
                        exp_k = q.pop_front();
                        check("word_index", 32'(v_index), 32'(exp_k));
                        check("word_data",  v_data,        acc_word(pat, exp_k));
                        check("word_last",  32'(v_last),  32'(exp_k == 63));
                    end
                    nwords++;
                end
                stall  = !ready_drv;
                p_data = v_data; p_idx = v_index; p_last = v_last; p_s1 = v_sel1; p_s2 = v_sel2;
            end else begin
                stall = 1'b0;
            end
            if (v_done) begin
                seen_done = 1'b1;
                if (poke_start) start_drv = 1'b1;
            end
            @(negedge CLK);
        end
        start_drv = 1'b0;
        ready_drv = 1'b0;

        check("done_seen",      32'(seen_done), 32'd1);
        check("word_count",     32'(nwords),    32'(exp_words));
        check("words_missing",  32'(q.size()),  32'd0);
        check("total_ones",     32'(v_total),   32'(exp_ones));
        check("busy_after_fin", 32'(v_busy),    32'd0);
        if (timing) begin
            check("first_latency", 32'(first_v),            32'd2);
            check("word_period",   32'(second_v - first_v), 32'd3);
        end

        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (v_done || v_valid || v_busy) extra++;
            @(negedge CLK);
        end
        check("quiet_after_done", 32'(extra), 32'd0);
        check("total_held",       32'(v_total), 32'(exp_ones));
    endtask

    // Reset pulse while word 17 is waiting in PUSH.
    task automatic reset_mid_scan();
        bit found;
        int extra;
        use_b   = 1'b0;
        pattern = 0;
        found   = 1'b0;
        @(negedge CLK);
        start_drv = 1'b1;
        @(negedge CLK);
        start_drv = 1'b0;
        for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
            if (v_valid && v_index == 6'd17) begin
                found     = 1'b1;
                RST_n     = 1'b0;
                ready_drv = 1'b1;
            end else begin
                ready_drv = 1'b1;
            end
            @(negedge CLK);
        end
        RST_n     = 1'b1;
        ready_drv = 1'b0;
        check("rst_hit_word17", 32'(found), 32'd1);
        check_reset_values();
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (v_done || v_valid || v_busy) extra++;
            @(negedge CLK);
        end
        check("no_done_after_rst", 32'(extra), 32'd0);
    endtask

    initial begin
        RST_n     = 1'b0;
        start_drv = 1'b0;
        ready_drv = 1'b0;
        use_b     = 1'b0;
        pattern   = 0;
        repeat (3) @(negedge CLK);
        check_reset_values();
        use_b = 1'b1;
        check("rst_b_valid", 32'(v_valid), 32'd0);
        check("rst_b_busy",  32'(v_busy),  32'd0);
        use_b = 1'b0;
        RST_n = 1'b1;
        @(negedge CLK);

        // Walking one per word: 64 ones, latency and word rate checked.
        run_scan(1'b0, 0, 100, 1'b1, 1'b0, 64, 12'd64);
        // Every bit set: 2048 edges, must not wrap.
        run_scan(1'b0, 1, 100, 1'b0, 1'b0, 64, 12'h800);
        // Sparse array with zero skipping: words 5, 40 and the terminal 63.
        run_scan(1'b1, 2, 100, 1'b0, 1'b0, 3, 12'd16);
        // Back-pressure at 30 percent ready.
        run_scan(1'b0, 3, 30, 1'b0, 1'b0, 64, model_ones(3));
        // Spurious starts mid-scan and in the done cycle, then a fresh scan.
        run_scan(1'b0, 1, 100, 1'b0, 1'b1, 64, 12'h800);
        run_scan(1'b0, 0, 100, 1'b0, 1'b0, 64, 12'd64);
        // Reset during PUSH of word 17, then a complete scan.
        reset_mid_scan();
        run_scan(1'b0, 3, 100, 1'b1, 1'b0, 64, model_ones(3));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
